// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding,
// R/W bit values and ACK/NACK line levels.
package i2c_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ACK,
      ST_WR_PTR,
      ST_WR_DATA,
      ST_RD_DATA,
      ST_RD_ACK,
      ST_IGNORE
   } i2c_tgt_state_t;

   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_if.sv
// Register-side strobe bus of the I2C target: the target is the master that
// issues write/read strobes, the external register file is the slave.
interface i2c_target_if;

   logic       wr_valid;
   logic [7:0] wr_addr;
   logic [7:0] wr_data;
   logic       rd_req;
   logic [7:0] rd_addr;
   logic [7:0] rd_data;
   logic       busy;

   modport master (
      output wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy,
      input  rd_data
   );

   modport slave (
      input  wr_valid, wr_addr, wr_data, rd_req, rd_addr, busy,
      output rd_data
   );

endinterface

// File: rtl/i2c_line_filter.sv
// Pad synchronizer plus edge detection for one I2C line. With
// I2C_TARGET_GLITCH_FILTER_EN defined, a 3-sample majority vote is inserted.
module i2c_line_filter #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic areset_n,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   line_s;
   logic                   prev_q;

   // Flops reset to the idle-bus level so reset release never looks like an edge.
   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;
   logic       maj;

   assign maj = (sync_q[SYNC_STAGES-1] & hist_q[0]) |
                (sync_q[SYNC_STAGES-1] & hist_q[1]) |
                (hist_q[0] & hist_q[1]);

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[0], sync_q[SYNC_STAGES-1]};
         filt_q <= maj;
      end
   end

   assign line_s = filt_q;
`else
   assign line_s = sync_q[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= line_s;
      end
   end

   assign level_o = line_s;
   assign rise_o  = line_s & ~prev_q;
   assign fall_o  = ~line_s & prev_q;

endmodule

// File: rtl/i2c_target.sv
// I2C target with pointer-then-data register protocol and an external
// write/read strobe interface. Optional macro: I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target
   import i2c_pkg::*;
#(
   parameter logic [6:0] I2C_SLAVE_ADDR = 7'd52,
   parameter int         SYNC_STAGES    = 2
) (
   input  logic       clk,
   input  logic       areset_n,
   input  logic       scl_i,
   input  logic       sda_i,
   output logic       sda_oe,
   output logic       wr_valid,
   output logic [7:0] wr_addr,
   output logic [7:0] wr_data,
   output logic       rd_req,
   output logic [7:0] rd_addr,
   input  logic [7:0] rd_data,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;
   logic start_det, stop_det;

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_scl_filt (
      .clk      (clk),
      .areset_n (areset_n),
      .line_i   (scl_i),
      .level_o  (scl_lvl),
      .rise_o   (scl_rise),
      .fall_o   (scl_fall)
   );

   i2c_line_filter #(.SYNC_STAGES(SYNC_STAGES)) u_sda_filt (
      .clk      (clk),
      .areset_n (areset_n),
      .line_i   (sda_i),
      .level_o  (sda_lvl),
      .rise_o   (sda_rise),
      .fall_o   (sda_fall)
   );

   assign start_det = sda_fall & scl_lvl;
   assign stop_det  = sda_rise & scl_lvl;

   i2c_tgt_state_t state_q, state_d;
   i2c_tgt_state_t after_ack_q, after_ack_d;
   logic [3:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]     shift_q, shift_d;
   logic [7:0]     ptr_q, ptr_d;
   logic           sda_oe_q, sda_oe_d;
   logic           busy_q, busy_d;
   logic           wr_valid_q, wr_valid_d;
   logic [7:0]     wr_addr_q, wr_addr_d;
   logic [7:0]     wr_data_q, wr_data_d;
   logic           rd_req_q, rd_req_d;
   logic [7:0]     rd_addr_q, rd_addr_d;
   logic           load_q;

   logic [7:0] byte_in;
   logic       last_bit;

   assign byte_in  = {shift_q[6:0], sda_lvl};
   assign last_bit = (bit_cnt_q == 4'd7);

   always_ff @(posedge clk or negedge areset_n) begin
      if (!areset_n) begin
         state_q     <= ST_IDLE;
         after_ack_q <= ST_IDLE;
         bit_cnt_q   <= 4'd0;
         shift_q     <= 8'd0;
         ptr_q       <= 8'd0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_valid_q  <= 1'b0;
         wr_addr_q   <= 8'd0;
         wr_data_q   <= 8'd0;
         rd_req_q    <= 1'b0;
         rd_addr_q   <= 8'd0;
         load_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         after_ack_q <= after_ack_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         ptr_q       <= ptr_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_valid_q  <= wr_valid_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         rd_req_q    <= rd_req_d;
         rd_addr_q   <= rd_addr_d;
         load_q      <= rd_req_q;
      end
   end

   always_comb begin
      state_d     = state_q;
      after_ack_d = after_ack_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      ptr_d       = ptr_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_valid_d  = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      rd_req_d    = 1'b0;
      rd_addr_d   = rd_addr_q;

      // Register file answers one cycle after rd_req; capture it for transmit.
      if (load_q) begin
         shift_d = rd_data;
      end

      if (stop_det) begin
         state_d   = ST_IDLE;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
         bit_cnt_d = 4'd0;
      end else if (start_det) begin
         state_d   = ST_ADDR;
         sda_oe_d  = 1'b0;
         bit_cnt_d = 4'd0;
      end else begin
         unique case (state_q)
            ST_IDLE, ST_IGNORE: begin
            end

            ST_ADDR: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_d = 4'd0;
                     if (byte_in[7:1] == I2C_SLAVE_ADDR) begin
                        busy_d  = 1'b1;
                        state_d = ST_ACK;
                        case (byte_in[0])
                           I2C_RW_WRITE: after_ack_d = ST_WR_PTR;
                           I2C_RW_READ:  after_ack_d = ST_RD_DATA;
                           default:      after_ack_d = ST_WR_PTR;
                        endcase
                     end else begin
                        busy_d  = 1'b0;
                        state_d = ST_IGNORE;
                     end
                  end
               end
            end

            ST_WR_PTR: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_d   = 4'd0;
                     ptr_d       = byte_in;
                     state_d     = ST_ACK;
                     after_ack_d = ST_WR_DATA;
                  end
               end
            end

            ST_WR_DATA: begin
               if (scl_rise) begin
                  shift_d   = byte_in;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (last_bit) begin
                     bit_cnt_d   = 4'd0;
                     wr_valid_d  = 1'b1;
                     wr_addr_d   = ptr_q;
                     wr_data_d   = byte_in;
                     ptr_d       = ptr_q + 8'd1;
                     state_d     = ST_ACK;
                     after_ack_d = ST_WR_DATA;
                  end
               end
            end

            // First fall drives the ACK, second fall ends it and hands over.
            ST_ACK: begin
               if (scl_fall) begin
                  if (!sda_oe_q) begin
                     sda_oe_d = ~I2C_ACK;
                  end else begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = after_ack_q;
                     if (after_ack_q == ST_RD_DATA) begin
                        sda_oe_d = ~shift_q[7];
                     end
                  end
               end else if (scl_rise && sda_oe_q && (after_ack_q == ST_RD_DATA)) begin
                  rd_req_d  = 1'b1;
                  rd_addr_d = ptr_q;
               end
            end

            ST_RD_DATA: begin
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     sda_oe_d  = 1'b0;
                     bit_cnt_d = 4'd0;
                     state_d   = ST_RD_ACK;
                  end else begin
                     shift_d  = {shift_q[6:0], 1'b0};
                     sda_oe_d = ~shift_q[6];
                  end
               end
            end

            // bit_cnt_q doubles as "master acknowledged" until the next fall.
            ST_RD_ACK: begin
               if (scl_rise) begin
                  if (sda_lvl == I2C_NACK) begin
                     busy_d  = 1'b0;
                     state_d = ST_IGNORE;
                  end else begin
                     ptr_d     = ptr_q + 8'd1;
                     rd_req_d  = 1'b1;
                     rd_addr_d = ptr_q + 8'd1;
                     bit_cnt_d = 4'd1;
                  end
               end else if (scl_fall && (bit_cnt_q == 4'd1)) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = ~shift_q[7];
                  state_d   = ST_RD_DATA;
               end
            end
         endcase
      end
   end

   assign sda_oe   = sda_oe_q;
   assign busy     = busy_q;
   assign wr_valid = wr_valid_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;
   assign rd_req   = rd_req_q;
   assign rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged I2C master, register-file model
// answering rd_data = addr ^ 0x5A, and strobe logging on the register bus.
`timescale 1ns/1ps
module tb_i2c_target;

   localparam int Q = 10;

   logic clk      = 1'b0;
   logic areset_n = 1'b0;
   logic scl      = 1'b1;
   logic sda_m    = 1'b1;
   logic sda_oe;
   wire  sda_bus;

   i2c_target_if rif ();

   assign sda_bus = sda_m & ~sda_oe;

   always #50 clk = ~clk;

   i2c_target #(
      .I2C_SLAVE_ADDR (7'd52),
      .SYNC_STAGES    (2)
   ) dut (
      .clk      (clk),
      .areset_n (areset_n),
      .scl_i    (scl),
      .sda_i    (sda_bus),
      .sda_oe   (sda_oe),
      .wr_valid (rif.wr_valid),
      .wr_addr  (rif.wr_addr),
      .wr_data  (rif.wr_data),
      .rd_req   (rif.rd_req),
      .rd_addr  (rif.rd_addr),
      .rd_data  (rif.rd_data),
      .busy     (rif.busy)
   );

   int tests = 0;
   int fails = 0;

   logic [7:0] wr_a_log [32];
   logic [7:0] wr_d_log [32];
   logic [7:0] rd_a_log [32];
   int wr_cnt      = 0;
   int rd_cnt      = 0;
   int sda_low_cnt = 0;
   int busy_cnt    = 0;

   // Register file: synchronous read, data valid the cycle after rd_req.
   always @(posedge clk) begin
      if (!areset_n) rif.rd_data <= 8'h00;
      else if (rif.rd_req) rif.rd_data <= rif.rd_addr ^ 8'h5A;
   end

   always @(negedge clk) begin
      if (rif.wr_valid) begin
         if (wr_cnt < 32) begin
            wr_a_log[wr_cnt[4:0]] <= rif.wr_addr;
            wr_d_log[wr_cnt[4:0]] <= rif.wr_data;
         end
         wr_cnt <= wr_cnt + 1;
      end
      if (rif.rd_req) begin
         if (rd_cnt < 32) rd_a_log[rd_cnt[4:0]] <= rif.rd_addr;
         rd_cnt <= rd_cnt + 1;
      end
      if (sda_oe)   sda_low_cnt <= sda_low_cnt + 1;
      if (rif.busy) busy_cnt    <= busy_cnt + 1;
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_start();
      if (!scl) begin
         sda_m = 1'b1; wait_clks(Q);
         scl   = 1'b1; wait_clks(Q);
      end
      sda_m = 1'b0; wait_clks(Q);
      scl   = 1'b0; wait_clks(Q);
   endtask

   task automatic send_stop();
      if (scl) begin
         scl = 1'b0; wait_clks(Q);
      end
      sda_m = 1'b0; wait_clks(Q);
      scl   = 1'b1; wait_clks(Q);
      sda_m = 1'b1; wait_clks(2*Q);
   endtask

   task automatic put_bit(input logic b, input logic glitch);
      sda_m = b; wait_clks(Q);
      scl   = 1'b1;
      if (glitch) begin
         wait_clks(Q);
         scl = 1'b0; wait_clks(1);
         scl = 1'b1; wait_clks(Q-1);
      end else begin
         wait_clks(2*Q);
      end
      scl = 1'b0; wait_clks(Q);
   endtask

   task automatic get_bit(output logic b);
      sda_m = 1'b1; wait_clks(Q);
      scl   = 1'b1; wait_clks(Q);
      b     = sda_bus; wait_clks(Q);
      scl   = 1'b0; wait_clks(Q);
   endtask

   task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic acked);
      logic b;
      for (int i = 7; i >= 0; i--) put_bit(d[i], i == glitch_bit);
      get_bit(b);
      acked = (b == 1'b0);
      $display("[TB] wrote byte 0x%02h ack=%0b", d, acked);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      for (int i = 7; i >= 0; i--) begin
         get_bit(b);
         d[i] = b;
      end
      put_bit(ack ? 1'b0 : 1'b1, 1'b0);
      $display("[TB] read byte 0x%02h master_ack=%0b", d, ack);
   endtask

   task automatic test_reset();
      areset_n = 1'b0;
      wait_clks(5);
      tests++;
      if ({sda_oe, rif.wr_valid, rif.wr_addr, rif.wr_data, rif.rd_req, rif.rd_addr, rif.busy} !== 28'd0) begin
         fails++;
         $display("FAIL reset_outputs: got sda_oe=%b wrv=%b wa=%h wd=%h rr=%b ra=%h busy=%b, required all 0",
                  sda_oe, rif.wr_valid, rif.wr_addr, rif.wr_data, rif.rd_req, rif.rd_addr, rif.busy);
      end
      areset_n = 1'b1;
      wait_clks(2*Q);
      tests++;
      if ({sda_oe, rif.busy} !== 2'b00) begin
         fails++;
         $display("FAIL reset_idle: got sda_oe=%b busy=%b, required 0 0", sda_oe, rif.busy);
      end
      $display("[TB] reset done");
   endtask

   task automatic test_write();
      logic a0, a1, a2, a3;
      int   base = wr_cnt;
      send_start();
      write_byte(8'h68, -1, a0);
      write_byte(8'h10, -1, a1);
      write_byte(8'hAB, -1, a2);
      write_byte(8'hCD, -1, a3);
      tests++;
      if ({a0, a1, a2, a3} !== 4'b1111) begin
         fails++;
         $display("FAIL write_acks: got %b, required 1111", {a0, a1, a2, a3});
      end
      tests++;
      if (rif.busy !== 1'b1) begin
         fails++;
         $display("FAIL write_busy_active: got %b, required 1", rif.busy);
      end
      send_stop();
      tests++;
      if (rif.busy !== 1'b0) begin
         fails++;
         $display("FAIL write_busy_stop: got %b, required 0", rif.busy);
      end
      tests++;
      if (wr_cnt - base !== 2) begin
         fails++;
         $display("FAIL write_count: got %0d, required 2", wr_cnt - base);
      end else begin
         tests++;
         if ({wr_a_log[base], wr_d_log[base]} !== 16'h10AB) begin
            fails++;
            $display("FAIL write_first: got %h=%h, required 10=ab", wr_a_log[base], wr_d_log[base]);
         end
         tests++;
         if ({wr_a_log[base+1], wr_d_log[base+1]} !== 16'h11CD) begin
            fails++;
            $display("FAIL write_second: got %h=%h, required 11=cd", wr_a_log[base+1], wr_d_log[base+1]);
         end
      end
   endtask

   task automatic test_combined_read();
      logic       a0, a1, a2;
      logic [7:0] d0, d1;
      int         wbase = wr_cnt;
      int         rbase = rd_cnt;
      send_start();
      write_byte(8'h68, -1, a0);
      write_byte(8'h20, -1, a1);
      send_start();
      write_byte(8'h69, -1, a2);
      read_byte(d0, 1'b1);
      read_byte(d1, 1'b0);
      tests++;
      if (rif.busy !== 1'b0) begin
         fails++;
         $display("FAIL read_busy_nack: got %b, required 0", rif.busy);
      end
      send_stop();
      tests++;
      if ({a0, a1, a2} !== 3'b111) begin
         fails++;
         $display("FAIL read_acks: got %b, required 111", {a0, a1, a2});
      end
      tests++;
      if (d0 !== 8'h7A) begin
         fails++;
         $display("FAIL read_byte0: got %h, required 7a", d0);
      end
      tests++;
      if (d1 !== 8'h7B) begin
         fails++;
         $display("FAIL read_byte1: got %h, required 7b", d1);
      end
      tests++;
      if (wr_cnt - wbase !== 0) begin
         fails++;
         $display("FAIL read_no_write: got %0d writes, required 0", wr_cnt - wbase);
      end
      tests++;
      if (rd_cnt - rbase !== 2) begin
         fails++;
         $display("FAIL read_req_count: got %0d, required 2", rd_cnt - rbase);
      end else begin
         tests++;
         if ({rd_a_log[rbase], rd_a_log[rbase+1]} !== 16'h2021) begin
            fails++;
            $display("FAIL read_req_addr: got %h %h, required 20 21", rd_a_log[rbase], rd_a_log[rbase+1]);
         end
      end
   endtask

   task automatic test_mismatch();
      logic a0, a1;
      int   wbase = wr_cnt;
      int   rbase = rd_cnt;
      int   sbase = sda_low_cnt;
      int   bbase = busy_cnt;
      send_start();
      write_byte(8'h6A, -1, a0);
      write_byte(8'h00, -1, a1);
      send_stop();
      tests++;
      if ({a0, a1} !== 2'b00) begin
         fails++;
         $display("FAIL mismatch_acks: got %b, required 00", {a0, a1});
      end
      tests++;
      if (sda_low_cnt - sbase !== 0) begin
         fails++;
         $display("FAIL mismatch_sda: got %0d driven cycles, required 0", sda_low_cnt - sbase);
      end
      tests++;
      if ((wr_cnt - wbase) + (rd_cnt - rbase) !== 0) begin
         fails++;
         $display("FAIL mismatch_strobes: got wr=%0d rd=%0d, required 0 0", wr_cnt - wbase, rd_cnt - rbase);
      end
      tests++;
      if (busy_cnt - bbase !== 0) begin
         fails++;
         $display("FAIL mismatch_busy: got %0d busy cycles, required 0", busy_cnt - bbase);
      end
   endtask

   task automatic test_wrap();
      logic a0, a1, a2, a3;
      int   base = wr_cnt;
      send_start();
      write_byte(8'h68, -1, a0);
      write_byte(8'hFF, -1, a1);
      write_byte(8'h11, -1, a2);
      write_byte(8'h22, -1, a3);
      send_stop();
      tests++;
      if (wr_cnt - base !== 2) begin
         fails++;
         $display("FAIL wrap_count: got %0d, required 2", wr_cnt - base);
      end else begin
         tests++;
         if ({wr_a_log[base], wr_d_log[base], wr_a_log[base+1], wr_d_log[base+1]} !== 32'hFF11_0022) begin
            fails++;
            $display("FAIL wrap_writes: got %h=%h %h=%h, required ff=11 00=22",
                     wr_a_log[base], wr_d_log[base], wr_a_log[base+1], wr_d_log[base+1]);
         end
      end
   endtask

   task automatic test_stop_partial();
      logic a0, a1;
      int   base = wr_cnt;
      send_start();
      write_byte(8'h68, -1, a0);
      write_byte(8'h30, -1, a1);
      for (int i = 0; i < 5; i++) put_bit(1'b1, 1'b0);
      send_stop();
      $display("[TB] stop after 5 data bits");
      tests++;
      if (wr_cnt - base !== 0) begin
         fails++;
         $display("FAIL partial_no_write: got %0d writes, required 0", wr_cnt - base);
      end
      tests++;
      if (rif.busy !== 1'b0) begin
         fails++;
         $display("FAIL partial_busy: got %b, required 0", rif.busy);
      end
   endtask

   task automatic test_reset_mid();
      logic       a0, a1, a2, a3;
      logic [7:0] d;
      int         rbase;
      send_start();
      write_byte(8'h68, -1, a0);
      write_byte(8'h40, -1, a1);
      write_byte(8'h12, -1, a2);
      for (int i = 0; i < 3; i++) put_bit(1'b1, 1'b0);
      sda_m = 1'b0; wait_clks(Q);
      scl   = 1'b1; wait_clks(Q);
      tests++;
      if ({rif.busy, rif.wr_addr} !== 9'h140) begin
         fails++;
         $display("FAIL midreset_before: got busy=%b wa=%h, required 1 40", rif.busy, rif.wr_addr);
      end
      areset_n = 1'b0;
      #1;
      $display("[TB] reset asserted in 4th data bit");
      tests++;
      if ({sda_oe, rif.wr_valid, rif.wr_addr, rif.wr_data, rif.rd_req, rif.rd_addr, rif.busy} !== 28'd0) begin
         fails++;
         $display("FAIL midreset_outputs: got sda_oe=%b wrv=%b wa=%h wd=%h rr=%b ra=%h busy=%b, required all 0",
                  sda_oe, rif.wr_valid, rif.wr_addr, rif.wr_data, rif.rd_req, rif.rd_addr, rif.busy);
      end
      wait_clks(2);
      sda_m = 1'b1;
      wait_clks(Q);
      areset_n = 1'b1;
      wait_clks(2*Q);
      // Pointer must be back at 0 after reset.
      rbase = rd_cnt;
      send_start();
      write_byte(8'h69, -1, a3);
      read_byte(d, 1'b0);
      send_stop();
      tests++;
      if ({a3, d} !== 9'h15A) begin
         fails++;
         $display("FAIL midreset_ptr_read: got ack=%b data=%h, required 1 5a", a3, d);
      end
      tests++;
      if ((rd_cnt - rbase !== 1) || (rd_a_log[rbase] !== 8'h00)) begin
         fails++;
         $display("FAIL midreset_rd_addr: got %0d reqs first=%h, required 1 at 00", rd_cnt - rbase, rd_a_log[rbase]);
      end
   endtask

   task automatic test_glitch();
      logic       a0, a1, a2;
      logic [7:0] exp_d;
      int         base;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      exp_d = 8'hA5;
`else
      exp_d = 8'hB2;
`endif
      base = wr_cnt;
      send_start();
      write_byte(8'h68, -1, a0);
      write_byte(8'h50, -1, a1);
      write_byte(8'hA5, 5, a2);
      send_stop();
      tests++;
      if (wr_cnt - base !== 1) begin
         fails++;
         $display("FAIL glitch_count: got %0d writes, required 1", wr_cnt - base);
      end else begin
         tests++;
         if ({wr_a_log[base], wr_d_log[base]} !== {8'h50, exp_d}) begin
            fails++;
            $display("FAIL glitch_byte: got %h=%h, required 50=%h", wr_a_log[base], wr_d_log[base], exp_d);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_combined_read();
      test_mismatch();
      test_wrap();
      test_stop_partial();
      test_reset_mid();
      test_glitch();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/i2c_target.md
# i2c_target

I2C target (slave) responder, the far end of the existing `i2c_top` master on the same two-wire bus. It answers one 7-bit address and runs the standard pointer-then-data register protocol: the first written byte sets an 8-bit register pointer, and later bytes are written or read at the pointer, which auto-increments. Register storage lives outside the block behind a simple write/read strobe interface. The block is used as a bus-level counterpart in simulation and as a standalone target in the FPGA.

## Interface
Parameters:
- `I2C_SLAVE_ADDR`, default 7'd52: 7-bit address this target acknowledges.
- `SYNC_STAGES`, default 2: depth of the input synchronizer on SCL and SDA, minimum 2.

Ports:
- `clk`  in  1: system clock, 10 MHz nominal.
- `areset_n`  in  1: asynchronous active-low reset.
- `scl_i`  in  1: SCL pad input.
- `sda_i`  in  1: SDA pad input.
- `sda_oe`  out  1: 1 pulls SDA low; the pad logic drives 1'bz when this is 0.
- `wr_valid`  out  1: one-cycle strobe; `wr_addr` and `wr_data` are valid in that cycle.
- `wr_addr`  out  8: register address for the write.
- `wr_data`  out  8: write data.
- `rd_req`  out  1: one-cycle read request at `rd_addr`.
- `rd_addr`  out  8: register address for the read.
- `rd_data`  in  8: read data, sampled exactly one cycle after `rd_req`.
- `busy`  out  1: high from an addressed START to the following STOP, NACK-end, or START to another address.

## Operation
- SCL and SDA pass through a `SYNC_STAGES`-flop synchronizer, then edge detection on registered copies.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in any state.
- Bits are sampled on the SCL rising edge, MSB first. `sda_oe` changes only in the cycle after an SCL falling edge is detected.
- State machine:
  - IDLE: on START, go to ADDR.
  - ADDR: shift in 8 bits.
    - If the address matches and R/W=0, go to ACK, then WR_PTR.
    - If the address matches and R/W=1, go to ACK, then RD_DATA.
    - If the address does not match, go to IGNORE and leave `sda_oe` at 0.
  - WR_PTR: shift in 8 bits, load the pointer, go to ACK, then WR_DATA.
  - WR_DATA: shift in 8 bits.
    - At the 8th rising edge, pulse `wr_valid` with `wr_addr`=pointer and `wr_data`=byte.
    - The pointer increments in the same cycle.
    - Go to ACK, then WR_DATA.
  - ACK: drive `sda_oe`=1 from the falling edge after bit 8 until the next falling edge.
  - RD_DATA: drive the byte MSB first, with `sda_oe` = inverted bit. Release SDA after bit 0, then go to RD_ACK.
  - RD_ACK: sample the master's bit on the SCL rising edge.
    - ACK (0): go to RD_DATA.
    - NACK (1): go to IGNORE.
  - IGNORE: wait for START (go to ADDR) or STOP (go to IDLE).
- Read fetch:
  - `rd_req` pulses on the SCL rising edge of the ACK bit that precedes each read byte. `rd_addr` is the pointer.
  - `rd_data` is latched into the shift register on the next clock.
  - The pointer increments after each byte the master acknowledges.
- Pointer arithmetic is 8-bit modulo: 8'hFF+1 = 8'h00.
- Repeated START in any state: go to ADDR, keep the pointer, release SDA in the same cycle.
- STOP in any state: go to IDLE, `sda_oe`=0, `busy`=0.
- Any bit left incomplete by START or STOP is discarded. No `wr_valid` is issued for a partial byte.

## Timing
- Reset values: `sda_oe`=0, `wr_valid`=0, `wr_addr`=0, `wr_data`=0, `rd_req`=0, `rd_addr`=0, `busy`=0, pointer=0, state IDLE.
- Pad-to-decision latency is `SYNC_STAGES`+1 clocks, plus 2 clocks when the glitch filter is compiled in.
- `sda_oe` changes 1 clock after the detected SCL fall.
- At 100 kHz SCL the SCL-low half-period is about 50 clocks, so there is ample setup margin.
- `wr_valid` is high for exactly one cycle, issued `SYNC_STAGES`+1 clocks after the 8th SCL rise.
- No clock stretching: the external register interface must return `rd_data` in exactly 1 cycle.

## Configuration
- `I2C_TARGET_GLITCH_FILTER_EN` defined: a 3-sample majority filter follows the synchronizer on both SCL and SDA. Pulses of 1 clock are suppressed. Latency grows by 2 clocks.
- Not defined: synchronizer output feeds edge detection directly, and a 1-clock pulse is acted on.

## Structure
- Package `i2c_pkg`:
  - state enum `i2c_tgt_state_t`
  - `I2C_RW_WRITE`/`I2C_RW_READ` constants
  - `I2C_ACK`=1'b0, `I2C_NACK`=1'b1
- Sub-module `i2c_line_filter`: synchronizer, optional majority filter, rise/fall detection. Instantiated once each for SCL and SDA.
- The FSM, shift register and pointer live in `i2c_target`.

## Test plan
- Write: START, 0x68, 0x10, 0xAB, 0xCD, STOP.
  - All four bytes ACKed.
  - `wr_valid` pulses at (0x10, 0xAB) and (0x11, 0xCD).
  - `busy` drops at STOP.
- Combined read: START, 0x68, 0x20, Sr, 0x69, master reads 2 bytes with ACK then NACK, STOP.
  - Bench model returns `rd_data` = addr ^ 0x5A.
  - SDA carries 0x7A, then 0x7B.
  - `rd_req` is issued at 0x20 and 0x21.
- Address mismatch: START, 0x6A, 0x00, STOP.
  - SDA is never pulled low.
  - No `wr_valid`, no `rd_req`, `busy` stays 0.
- Pointer wrap: write pointer 0xFF, then data 0x11, 0x22.
  - Writes land at 0xFF, then 0x00.
- Mid-transfer disruption:
  - Assert `areset_n` low during the 4th data bit: all outputs return to reset values immediately.
  - Separately, STOP after 5 data bits: no `wr_valid`.
- 1-clock low glitch on SCL during a data bit:
  - With `I2C_TARGET_GLITCH_FILTER_EN`: the received byte is unchanged.
  - Without it: the corrupted byte is accepted, showing the filter is what provides the protection.
